// File: rtl/ula_req_scheduler.sv
// Arbitrates NREQ requesters onto one combinational ULA and returns the tagged result.
// Optional build macro ULA_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module ula_req_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [3*NREQ-1:0] req_op_i,
   input  logic [8*NREQ-1:0] req_a_i,
   input  logic [8*NREQ-1:0] req_b_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [7:0]        ula_srca_o,
   output logic [7:0]        ula_srcb_o,
   output logic [2:0]        ula_ctrl_o,
   input  logic [7:0]        ula_result_i,
   input  logic              ula_flagz_i,
   output logic              rsp_valid_o,
   output logic [IDW-1:0]    rsp_id_o,
   output logic [7:0]        rsp_data_o,
   output logic              rsp_flagz_o,
   input  logic              rsp_ready_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [7:0]     ula_srca_q, ula_srcb_q;
   logic [2:0]     ula_ctrl_q;
   logic [IDW-1:0] id_q;
   logic           rsp_valid_q, rsp_flagz_q;
   logic [IDW-1:0] rsp_id_q;
   logic [7:0]     rsp_data_q;
   logic           win_any;
   logic [IDW-1:0] win_id;
   logic           accept;

`ifdef ULA_FIXED_PRIO_EN
   // Descending scan so the lowest valid index is the last to be written.
   always_comb begin
      int idx;
      win_any = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = i;
         if (req_valid_i[idx[IDW-1:0]]) begin
            win_any = 1'b1;
            win_id  = idx[IDW-1:0];
         end
      end
   end
`else
   logic [IDW-1:0] rr_ptr_q;

   // Scan offsets from rr_ptr downwards so the smallest offset wins, wrapping at NREQ-1.
   always_comb begin
      int idx;
      win_any = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid_i[idx[IDW-1:0]]) begin
            win_any = 1'b1;
            win_id  = idx[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         rr_ptr_q <= '0;
      else if (accept)
         rr_ptr_q <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
   end
`endif

   assign accept      = (state_q == IDLE) && win_any;
   assign req_ready_o = (accept && rst_n_i) ? (NREQ'(1) << win_id) : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_any) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ULA operands only move on accept, so the ULA inputs stay quiet between ops.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ula_srca_q  <= '0;
         ula_srcb_q  <= '0;
         ula_ctrl_q  <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_flagz_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_any) begin
                  ula_ctrl_q <= req_op_i[3*win_id +: 3];
                  ula_srca_q <= req_a_i[8*win_id +: 8];
                  ula_srcb_q <= req_b_i[8*win_id +: 8];
                  id_q       <= win_id;
               end
            end
            EXEC: begin
               rsp_valid_q <= 1'b1;
               rsp_id_q    <= id_q;
               rsp_data_q  <= ula_result_i;
               // FlagZ is only meaningful for the compare/subtract codes.
               rsp_flagz_q <= ((ula_ctrl_q == 3'b101) || (ula_ctrl_q == 3'b110)) ? ula_flagz_i : 1'b0;
            end
            RESP: begin
               if (rsp_ready_i) rsp_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign ula_srca_o  = ula_srca_q;
   assign ula_srcb_o  = ula_srcb_q;
   assign ula_ctrl_o  = ula_ctrl_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_flagz_o = rsp_flagz_q;

endmodule

// File: tb/tb_ula_req_scheduler.sv
// Directed self-checking bench for ula_req_scheduler with a behavioural ULA attached.
// Build with ULA_FIXED_PRIO_EN to switch the round-robin expectations to fixed priority.
module tb_ula_req_scheduler;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [3*NREQ-1:0] req_op;
   logic [8*NREQ-1:0] req_a;
   logic [8*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        ula_srca, ula_srcb;
   logic [2:0]        ula_ctrl;
   logic [7:0]        ula_result;
   logic              ula_flagz;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_data;
   logic              rsp_flagz;
   logic              rsp_ready;

   int testsRun  = 0;
   int failCount = 0;

   ula_req_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_op_i     (req_op),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_ready_o  (req_ready),
      .ula_srca_o   (ula_srca),
      .ula_srcb_o   (ula_srcb),
      .ula_ctrl_o   (ula_ctrl),
      .ula_result_i (ula_result),
      .ula_flagz_i  (ula_flagz),
      .rsp_valid_o  (rsp_valid),
      .rsp_id_o     (rsp_id),
      .rsp_data_o   (rsp_data),
      .rsp_flagz_o  (rsp_flagz),
      .rsp_ready_i  (rsp_ready)
   );

   always #5 clk = ~clk;

   // Stand-in ULA: FlagZ always reflects the result, so masking is visible on non-compare codes.
   always_comb begin
      case (ula_ctrl)
         3'b000:  ula_result = ula_srca & ula_srcb;
         3'b001:  ula_result = ula_srca | ula_srcb;
         3'b010:  ula_result = ula_srca + ula_srcb;
         3'b101:  ula_result = ula_srca ^ ula_srcb;
         3'b110:  ula_result = ula_srca - ula_srcb;
         default: ula_result = 8'h00;
      endcase
      ula_flagz = (ula_result == 8'h00);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*i +: 3] = op;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rspReady);
      req_valid = valid;
      rsp_ready = rspReady;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rrOrder[5];
`ifdef ULA_FIXED_PRIO_EN
      rrOrder = '{0, 0, 0, 0, 0};
`else
      rrOrder = '{0, 1, 2, 3, 0};
`endif
      rst_n = 1'b0;
      req_valid = '0;
      req_op = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      step();
      step();
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_srca", 32'(ula_srca), 32'd0);
      checkOutput("reset_ctrl", 32'(ula_ctrl), 32'd0);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;

      // Reset while an op is in EXEC drops it.
      setReq(0, 3'b010, 8'h11, 8'h22);
      applyStimulus(4'b0001, 1'b0);
      checkOutput("midop_grant", 32'(req_ready), 32'b0001);
      step();
      applyStimulus(4'b0000, 1'b0);
      checkOutput("midop_exec_srca", 32'(ula_srca), 32'h11);
      checkOutput("midop_exec_ctrl", 32'(ula_ctrl), 32'd2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checkOutput("midop_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("midop_srca", 32'(ula_srca), 32'd0);
      checkOutput("midop_srcb", 32'(ula_srcb), 32'd0);
      checkOutput("midop_ctrl", 32'(ula_ctrl), 32'd0);

      // Single add with latency check; req1 queued behind it.
      setReq(0, 3'b010, 8'hF0, 8'h20);
      setReq(1, 3'b001, 8'h0F, 8'h30);
      applyStimulus(4'b0011, 1'b0);
      checkOutput("add_grant_rrptr0", 32'(req_ready), 32'b0001);
      step();
      applyStimulus(4'b0010, 1'b0);
      checkOutput("add_exec_srca", 32'(ula_srca), 32'hF0);
      checkOutput("add_exec_srcb", 32'(ula_srcb), 32'h20);
      checkOutput("add_exec_ctrl", 32'(ula_ctrl), 32'd2);
      checkOutput("add_exec_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("add_exec_ready", 32'(req_ready), 32'd0);
      step();
      checkOutput("add_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("add_rsp_data", 32'(rsp_data), 32'h10);
      checkOutput("add_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("add_rsp_flagz", 32'(rsp_flagz), 32'd0);
      applyStimulus(4'b0010, 1'b1);
      step();
      applyStimulus(4'b0010, 1'b0);
      checkOutput("or_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("or_grant", 32'(req_ready), 32'b0010);
      step();

      // req2 waits through EXEC and a backpressured RESP.
      setReq(2, 3'b110, 8'h5A, 8'h5A);
      applyStimulus(4'b0100, 1'b0);
      checkOutput("or_exec_ready", 32'(req_ready), 32'd0);
      step();
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("bp_rsp_data", 32'(rsp_data), 32'h3F);
         checkOutput("bp_rsp_id", 32'(rsp_id), 32'd1);
         checkOutput("bp_rsp_flagz", 32'(rsp_flagz), 32'd0);
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         checkOutput("bp_srca_hold", 32'(ula_srca), 32'h0F);
         step();
      end
      applyStimulus(4'b0100, 1'b1);
      step();
      applyStimulus(4'b0100, 1'b0);
      checkOutput("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("beq_grant", 32'(req_ready), 32'b0100);
      step();

      // BEQ with req1 flashing valid for one EXEC cycle only.
      setReq(1, 3'b010, 8'h01, 8'h01);
      applyStimulus(4'b0010, 1'b0);
      step();
      applyStimulus(4'b0000, 1'b0);
      checkOutput("beq_rsp_data", 32'(rsp_data), 32'h00);
      checkOutput("beq_rsp_flagz", 32'(rsp_flagz), 32'd1);
      checkOutput("beq_rsp_id", 32'(rsp_id), 32'd2);
      applyStimulus(4'b0000, 1'b1);
      step();
      setReq(2, 3'b000, 8'h00, 8'h00);
      applyStimulus(4'b0100, 1'b0);
      checkOutput("withdraw_grant", 32'(req_ready), 32'b0100);
      step();
      applyStimulus(4'b0000, 1'b0);
      step();
      checkOutput("mask_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("mask_rsp_data", 32'(rsp_data), 32'h00);
      checkOutput("mask_rsp_flagz", 32'(rsp_flagz), 32'd0);
      checkOutput("mask_rsp_id", 32'(rsp_id), 32'd2);
      applyStimulus(4'b0000, 1'b1);
      step();

      // All four requesting continuously from a fresh pointer.
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) setReq(i, 3'b010, 8'(i), 8'h01);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rr_reset_ready", 32'(req_ready), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < 5; g++) begin
         checkOutput("rr_grant", 32'(req_ready), 32'(1 << rrOrder[g]));
         step();
         checkOutput("rr_exec_ready", 32'(req_ready), 32'd0);
         step();
         checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("rr_rsp_id", 32'(rsp_id), 32'(rrOrder[g]));
         checkOutput("rr_rsp_data", 32'(rsp_data), 32'(rrOrder[g] + 1));
         step();
      end
      applyStimulus(4'b0000, 1'b0);
      step();

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
